// File: rtl/seq_function_unit.sv
// Multi-cycle function unit: single-cycle ALU opcodes, bit-serial shifts and
// a radix-2 shift-add unsigned multiply behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete here
// SHIFT | moving B one bit per cycle, cnt bits left
// MUL   | shift-add multiply, cnt iterations left
module seq_function_unit #(
    parameter int WIDTH = 8,
    parameter int SAW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       FS,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SAW-1:0]   SH_AMT,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] F_HI,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z
);

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    localparam logic [SAW-1:0] W_CNT = SAW'(WIDTH);

    state_t state, state_nx;

    logic [SAW-1:0]   cnt;
    logic             dir_left;
    logic [WIDTH-1:0] sr, mcand, hi, lo;

    logic [WIDTH-1:0] y, imm_f, sh_nx, hi_nx, lo_nx;
    logic [WIDTH:0]   sum, psum;
    logic             cin, imm_c, imm_v, imm_n, sh_c;
    logic [SAW-1:0]   sh_amt_c;
    logic             is_shift, is_mul, last;

    assign sh_amt_c = (SH_AMT > W_CNT) ? W_CNT : SH_AMT;
    assign is_shift = (FS == 4'b1101) || (FS == 4'b1110);
    assign is_mul   = (FS == 4'b1111);
    assign last     = (cnt == SAW'(1));
    assign busy     = (state != IDLE);

    // Arithmetic opcodes: FS[2:1] picks Y (0, B, ~B, all ones), FS[0] is carry-in.
    always_comb begin
        y     = '0;
        cin   = FS[0];
        imm_f = '0;
        imm_c = 1'b0;
        imm_v = 1'b0;
        case (FS[2:1])
            2'b00:   y = '0;
            2'b01:   y = B;
            2'b10:   y = ~B;
            default: y = '1;
        endcase
        sum = {1'b0, A} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        if (!FS[3]) begin
            imm_f = sum[WIDTH-1:0];
            imm_c = sum[WIDTH];
            imm_v = (A[WIDTH-1] == y[WIDTH-1]) && (imm_f[WIDTH-1] != A[WIDTH-1]);
        end else begin
            case (FS[2:0])
                3'b000:  imm_f = A & B;
                3'b001:  imm_f = A | B;
                3'b010:  imm_f = A ^ B;
                3'b011:  imm_f = ~A;
                default: imm_f = B;
            endcase
        end
    end

    assign imm_n = imm_f[WIDTH-1] ^ imm_v;

    always_comb begin
        sh_nx = dir_left ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        sh_c  = dir_left ? sr[WIDTH-1] : sr[0];
        psum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        hi_nx = psum[WIDTH:1];
        lo_nx = {psum[0], lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul)                              state_nx = MUL;
                    else if (is_shift && (sh_amt_c != '0))   state_nx = SHIFT;
                end
            end
            SHIFT, MUL: if (last) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dir_left <= 1'b0;
            sr       <= '0;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            F        <= '0;
            F_HI     <= '0;
            {V, C, N, Z} <= 4'b0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            mcand <= A;
                            hi    <= '0;
                            lo    <= B;
                            cnt   <= W_CNT;
                        end else if (is_shift && (sh_amt_c != '0)) begin
                            sr       <= B;
                            dir_left <= FS[1];
                            cnt      <= sh_amt_c;
                        end else begin
                            F    <= imm_f;
                            F_HI <= '0;
                            V    <= imm_v;
                            C    <= imm_c;
                            N    <= imm_n;
                            Z    <= (imm_f == '0);
                            done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    sr  <= sh_nx;
                    cnt <= cnt - SAW'(1);
                    if (last) begin
                        F    <= sh_nx;
                        F_HI <= '0;
                        V    <= 1'b0;
                        C    <= sh_c;
                        N    <= sh_nx[WIDTH-1];
                        Z    <= (sh_nx == '0);
                        done <= 1'b1;
                    end
                end
                MUL: begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt - SAW'(1);
                    if (last) begin
                        F    <= lo_nx;
                        F_HI <= hi_nx;
                        V    <= 1'b0;
                        C    <= (hi_nx != '0);
                        N    <= lo_nx[WIDTH-1];
                        Z    <= ({hi_nx, lo_nx} == '0);
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_function_unit.sv
// Bench for seq_function_unit: directed and random operations on WIDTH=8 and
// WIDTH=16 instances, compared against an arithmetic reference model.
module tb_seq_function_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, busy8, done8, V8, C8, N8, Z8;
    logic [3:0] FS8, SH8;
    logic [7:0] A8, B8, F8, FH8;

    logic        start16, busy16, done16, V16, C16, N16, Z16;
    logic [3:0]  FS16;
    logic [4:0]  SH16;
    logic [15:0] A16, B16, F16, FH16;

    seq_function_unit #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .FS(FS8), .A(A8), .B(B8), .SH_AMT(SH8),
        .busy(busy8), .done(done8), .F(F8), .F_HI(FH8), .V(V8), .C(C8), .N(N8), .Z(Z8)
    );

    seq_function_unit #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .FS(FS16), .A(A16), .B(B16), .SH_AMT(SH16),
        .busy(busy16), .done(done16), .F(F16), .F_HI(FH16), .V(V16), .C(C16), .N(N16), .Z(Z16)
    );

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: result, flags, edges from start to done, and cycles spent busy.
    function automatic void model(input int w, input logic [3:0] fs, input longint a,
                                  input longint b, input int sh,
                                  output longint f, output longint fhi,
                                  output logic v, output logic c, output logic n,
                                  output logic z, output int lat, output int bsy);
        longint mask, half, y, usum, ssum, sa, sy, p;
        int cin, k;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        f = 0; fhi = 0; v = 0; c = 0; n = 0; lat = 1; bsy = 0;
        case (fs)
            4'b0000, 4'b0001: y = 0;
            4'b0010, 4'b0011: y = b;
            4'b0100, 4'b0101: y = mask - b;
            4'b0110, 4'b0111: y = mask;
            default:          y = 0;
        endcase
        cin = int'(fs[0]);
        if (fs < 4'b1000) begin
            usum = a + y + cin;
            f    = usum & mask;
            c    = (usum > mask);
            sa   = (a >= half) ? a - 2 * half : a;
            sy   = (y >= half) ? y - 2 * half : y;
            ssum = sa + sy + cin;
            v    = (ssum >= half) || (ssum < -half);
            n    = (ssum < 0);
        end else begin
            case (fs)
                4'b1000: f = a & b;
                4'b1001: f = a | b;
                4'b1010: f = a ^ b;
                4'b1011: f = mask - a;
                4'b1100: f = b;
                4'b1101, 4'b1110: begin
                    k = (sh > w) ? w : sh;
                    f = (fs == 4'b1101) ? (b >> k) : ((b << k) & mask);
                    if (k > 0)
                        c = (fs == 4'b1101) ? (((b >> (k - 1)) & 1) != 0)
                                            : (((b >> (w - k)) & 1) != 0);
                    bsy = k;
                    lat = k + 1;
                end
                default: begin
                    p   = a * b;
                    f   = p & mask;
                    fhi = p >> w;
                    c   = (fhi != 0);
                    bsy = w;
                    lat = w + 1;
                end
            endcase
            n = (((f >> (w - 1)) & 1) != 0);
        end
        z = (f == 0) && (fhi == 0);
    endfunction

    task automatic go8(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sh, input bit poke);
        longint ef, eh;
        logic ev, ec, en, ez;
        int lat, bsy, edges, nb;
        model(8, fs, longint'(a), longint'(b), int'(sh), ef, eh, ev, ec, en, ez, lat, bsy);
        FS8 = fs; A8 = a; B8 = b; SH8 = sh; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        FS8 = 4'($urandom); A8 = 8'($urandom); B8 = 8'($urandom); SH8 = 4'($urandom);
        edges = 1; nb = 0;
        while (done8 !== 1'b1 && edges < 40) begin
            nb += int'(busy8);
            if (poke && edges == 2) begin
                FS8 = 4'b0010;
                start8 = 1'b1;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            edges++;
        end
        nb += int'(busy8);
        chk("latency8", 64'(edges), 64'(lat));
        chk("busy8_cycles", 64'(nb), 64'(bsy));
        chk("F8", 64'(F8), 64'(ef));
        chk("F_HI8", 64'(FH8), 64'(eh));
        chk("flags8_VCNZ", 64'({V8, C8, N8, Z8}), 64'({ev, ec, en, ez}));
    endtask

    task automatic go16(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] sh);
        longint ef, eh;
        logic ev, ec, en, ez;
        int lat, bsy, edges, nb;
        model(16, fs, longint'(a), longint'(b), int'(sh), ef, eh, ev, ec, en, ez, lat, bsy);
        FS16 = fs; A16 = a; B16 = b; SH16 = sh; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        A16 = 16'($urandom); B16 = 16'($urandom); SH16 = 5'($urandom);
        edges = 1; nb = 0;
        while (done16 !== 1'b1 && edges < 60) begin
            nb += int'(busy16);
            @(posedge clk); #1;
            edges++;
        end
        nb += int'(busy16);
        chk("latency16", 64'(edges), 64'(lat));
        chk("busy16_cycles", 64'(nb), 64'(bsy));
        chk("F16", 64'(F16), 64'(ef));
        chk("F_HI16", 64'(FH16), 64'(eh));
        chk("flags16_VCNZ", 64'({V16, C16, N16, Z16}), 64'({ev, ec, en, ez}));
    endtask

    initial begin
        int nd;
        rst = 1'b1;
        start8 = 1'b0; FS8 = '0; A8 = '0; B8 = '0; SH8 = '0;
        start16 = 1'b0; FS16 = '0; A16 = '0; B16 = '0; SH16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_done", 64'({busy8, done8}), 64'(0));
        chk("rst_F_FHI", 64'({F8, FH8}), 64'(0));
        chk("rst_flags", 64'({V8, C8, N8, Z8}), 64'(0));
        chk("rst16_all", 64'({busy16, done16, F16, FH16, V16, C16, N16, Z16}), 64'(0));
        rst = 1'b0;

        go8(4'b0010, 8'h7F, 8'h01, 4'd0, 1'b0);
        go8(4'b0101, 8'h05, 8'h05, 4'd0, 1'b0);
        go8(4'b0110, 8'h00, 8'h33, 4'd0, 1'b0);
        go8(4'b0111, 8'hA5, 8'h00, 4'd0, 1'b0);
        go8(4'b1110, 8'h00, 8'h31, 4'd3, 1'b0);
        go8(4'b1101, 8'h00, 8'h5A, 4'd0, 1'b0);
        go8(4'b1101, 8'h00, 8'hC3, 4'd15, 1'b0);
        go8(4'b1110, 8'h00, 8'h81, 4'd8, 1'b0);
        go8(4'b1111, 8'hFF, 8'hFF, 4'd0, 1'b0);
        go8(4'b1111, 8'h00, 8'h9C, 4'd0, 1'b0);
        go8(4'b1111, 8'h23, 8'h45, 4'd0, 1'b1);
        go8(4'b0001, 8'h10, 8'h00, 4'd0, 1'b0);

        // Abort a multiply with reset three cycles after its start edge.
        FS8 = 4'b1111; A8 = 8'h37; B8 = 8'h05; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy_done", 64'({busy8, done8}), 64'(0));
        chk("abort_F_FHI", 64'({F8, FH8}), 64'(0));
        chk("abort_flags", 64'({V8, C8, N8, Z8}), 64'(0));
        nd = 0;
        repeat (12) begin
            nd += int'(done8);
            @(posedge clk); #1;
        end
        nd += int'(done8);
        chk("abort_no_done", 64'(nd), 64'(0));

        for (int i = 0; i < 80; i++)
            go8(4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b0);

        go16(4'b1111, 16'hFFFF, 16'h0002, 5'd0);
        go16(4'b1111, 16'hFFFF, 16'hFFFF, 5'd0);
        for (int i = 0; i < 12; i++)
            go16(4'($urandom), 16'($urandom), 16'($urandom), 5'($urandom_range(0, 20)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
